// File: rtl/llq_pkg.sv
// Shared types and small helpers for the dpsram read-stream front end.
package llq_pkg;
    localparam int DEF_W = 32;
    localparam int DEF_N = 128;

    typedef logic [$clog2(DEF_N)-1:0] addr_t;
    typedef logic [DEF_W-1:0]         data_t;

    // Pointer width for a circular buffer; a single-entry buffer still needs one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/rd_stream_fifo.sv
// Circular response buffer with a registered head output; depth need not be a power of two.
module rd_stream_fifo
    import llq_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [W-1:0]                 din,
    input  logic                         pop,
    output logic [W-1:0]                 dout,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   occ
);
    localparam int PW = ptr_w(DEPTH);
    localparam int OW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [W-1:0]  mem_reg [DEPTH];
    logic [PW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [OW-1:0] occ_reg, occ_next;
    logic [W-1:0]  dout_reg, dout_next;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign full  = (occ_reg == OW'(DEPTH));
    assign empty = (occ_reg == '0);
    assign occ   = occ_reg;
    assign dout  = dout_reg;

    always_comb begin
        occ_next    = occ_reg;
        rd_ptr_next = pop ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
        if (push && !pop) begin
            occ_next = occ_reg + OW'(1);
        end else if (pop && !push) begin
            occ_next = occ_reg - OW'(1);
        end
        // Preload the next head; bypass the array when the entry being pushed becomes the head.
        dout_next = dout_reg;
        if (occ_next != '0) begin
            if (push && (wr_ptr_reg == rd_ptr_next)) begin
                dout_next = din;
            end else begin
                dout_next = mem_reg[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            occ_reg    <= '0;
            dout_reg   <= '0;
        end else begin
            wr_ptr_reg <= push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
            rd_ptr_reg <= rd_ptr_next;
            occ_reg    <= occ_next;
            dout_reg   <= dout_next;
            assert (!(push && full));
            assert (!(pop && empty));
        end
    end
endmodule

// File: rtl/dpsram_rd_stream.sv
// Read-side front end for one dpsram port: credit-gated issue, 1-cycle capture, ordered response stream.
module dpsram_rd_stream
    import llq_pkg::*;
#(
    parameter int W     = DEF_W,
    parameter int N     = DEF_N,
    parameter int DEPTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_vld,
    input  logic [$clog2(N)-1:0]  req_addr,
    output logic                  req_rdy,
    output logic                  sram_csn,
    output logic                  sram_wen,
    output logic                  sram_oen,
    output logic [$clog2(N)-1:0]  sram_a,
    output logic [W-1:0]          sram_di,
    input  logic [W-1:0]          sram_dout,
    output logic                  rsp_vld,
    output logic [W-1:0]          rsp_data,
    input  logic                  rsp_rdy
);
    localparam int AW = $clog2(N);
    localparam int OW = $clog2(DEPTH + 1);

    logic           inflight_reg;
    logic [AW-1:0]  a_hold_reg;
    logic           issue;
    logic           fifo_full, fifo_empty;
    logic [OW-1:0]  occ;
    logic           hold_chk_reg;
    logic [W-1:0]   data_chk_reg;

    // Credit uses registered terms only, so rsp_rdy never reaches req_rdy combinationally.
    assign req_rdy = rst_n && ((int'(occ) + int'(inflight_reg)) < DEPTH);
    assign issue   = req_vld && req_rdy;

    assign sram_csn = ~issue;
    assign sram_oen = ~issue;
    assign sram_wen = 1'b1;
    assign sram_di  = '0;
    assign sram_a   = issue ? req_addr : a_hold_reg;

    assign rsp_vld = ~fifo_empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight_reg <= 1'b0;
            a_hold_reg   <= '0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                a_hold_reg <= req_addr;
            end
        end
    end

    rd_stream_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_reg),
        .din   (sram_dout),
        .pop   (rsp_vld && rsp_rdy),
        .dout  (rsp_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .occ   (occ)
    );

    // Checker state: remembers a stalled response so its data can be compared next cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hold_chk_reg <= 1'b0;
            data_chk_reg <= '0;
        end else begin
            hold_chk_reg <= rsp_vld && !rsp_rdy;
            data_chk_reg <= rsp_data;
            if (hold_chk_reg) begin
                assert (rsp_data == data_chk_reg);
            end
            assert (sram_wen);
            assert ((int'(occ) + int'(inflight_reg)) <= DEPTH);
            assert (!(inflight_reg && fifo_full));
        end
    end
endmodule
